// File: rtl/interrupt_controller12_if.sv
// Bundle of the interrupt request lines, configuration bus and processor
// handshake shared by the controller and whatever drives it.
interface interrupt_controller12_if;
    logic [23:0] irq;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [11:0] cfg_wdata;
    logic [11:0] cfg_rdata;
    logic        int_req;
    logic [4:0]  int_id;
    logic [23:0] int_vector;
    logic        int_ack;
    logic        int_done;
    logic        in_service;

    modport master (
        output irq, cfg_wr, cfg_addr, cfg_wdata, int_ack, int_done,
        input  cfg_rdata, int_req, int_id, int_vector, in_service
    );

    modport slave (
        input  irq, cfg_wr, cfg_addr, cfg_wdata, int_ack, int_done,
        output cfg_rdata, int_req, int_id, int_vector, in_service
    );
endinterface

// File: rtl/interrupt_controller12.sv
// 24-line edge-triggered interrupt controller: per-line mask, W1C pending,
// fixed lowest-index-first priority and a single-level request/service handshake.
module interrupt_controller12 #(
    parameter logic [23:0] VECTOR_BASE = 24'o00000100
) (
    input  logic                      clk,
    input  logic                      rst,
    interrupt_controller12_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t      state_reg, state_next;
    logic [23:0] irq_prev_reg;
    logic [23:0] pending_reg, pending_next;
    logic [23:0] mask_reg, mask_next;
    logic [4:0]  int_id_reg, int_id_next;
    logic [23:0] rise, cfg_clr, ack_clr, eligible;
    logic [4:0]  top_id;

    for (genvar gi = 0; gi < 24; gi++) begin : g_rise
        assign rise[gi] = bus.irq[gi] & ~irq_prev_reg[gi];
    end

    always_comb begin
        cfg_clr   = '0;
        mask_next = mask_reg;
        if (bus.cfg_wr) begin
            case (bus.cfg_addr)
                2'd0:    mask_next[11:0]  = bus.cfg_wdata;
                2'd1:    mask_next[23:12] = bus.cfg_wdata;
                2'd2:    cfg_clr[11:0]    = bus.cfg_wdata;
                default: cfg_clr[23:12]   = bus.cfg_wdata;
            endcase
        end
    end

    assign ack_clr      = (state_reg == REQ && bus.int_ack) ? (24'd1 << int_id_reg) : 24'd0;
    // New edges are OR-ed in last so a set beats a clear on the same bit.
    assign pending_next = (pending_reg & ~(cfg_clr | ack_clr)) | rise;
    assign eligible     = pending_reg & mask_reg;

    always_comb begin
        top_id = 5'd0;
        for (int i = 23; i >= 0; i--) begin
            if (eligible[i]) top_id = 5'(i);
        end
    end

    always_comb begin
        state_next  = state_reg;
        int_id_next = int_id_reg;
        case (state_reg)
            IDLE: begin
                if (eligible != 24'd0) begin
                    state_next  = REQ;
                    int_id_next = top_id;
                end
            end
            REQ: begin
                // Ack takes precedence; otherwise withdraw once the line is no longer live.
                if (bus.int_ack)
                    state_next = SERVICE;
                else if (!(pending_next[int_id_reg] && mask_reg[int_id_reg]))
                    state_next = IDLE;
            end
            SERVICE: begin
                if (bus.int_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            irq_prev_reg <= '0;
            pending_reg  <= '0;
            mask_reg     <= '0;
            int_id_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            irq_prev_reg <= bus.irq;
            pending_reg  <= pending_next;
            mask_reg     <= mask_next;
            int_id_reg   <= int_id_next;
        end
    end

    assign bus.int_req    = (state_reg == REQ);
    assign bus.in_service = (state_reg == SERVICE);
    assign bus.int_id     = int_id_reg;
    assign bus.int_vector = VECTOR_BASE + {18'd0, int_id_reg, 1'b0};

    always_comb begin
        case (bus.cfg_addr)
            2'd0:    bus.cfg_rdata = mask_reg[11:0];
            2'd1:    bus.cfg_rdata = mask_reg[23:12];
            2'd2:    bus.cfg_rdata = pending_reg[11:0];
            default: bus.cfg_rdata = pending_reg[23:12];
        endcase
    end
endmodule

// File: tb/tb_interrupt_controller12.sv
// Randomized scoreboard bench for interrupt_controller12 with directed scenarios
// and a behavioural reference model.
module tb_interrupt_controller12;
    localparam logic [23:0] BASE = 24'o00000100;

    logic clk;
    logic rst;
    interrupt_controller12_if bus();

    interrupt_controller12 #(.VECTOR_BASE(BASE)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        svc;
        logic [4:0]  id;
        logic [23:0] vec;
        logic [11:0] rdata;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    // Reference model: phase 0 idle, 1 requesting, 2 servicing.
    logic [23:0] m_pend, m_mask, m_prev;
    int          m_phase, m_id;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0; m_phase = 0; m_id = 0;
    endtask

    task automatic step(input logic [23:0] i_irq, input logic w, input logic [1:0] a,
                        input logic [11:0] d, input logic ack, input logic done);
        logic [23:0] rise, clr, elig, after;
        exp_t e;
        @(negedge clk); #1;
        bus.irq = i_irq; bus.cfg_wr = w; bus.cfg_addr = a; bus.cfg_wdata = d;
        bus.int_ack = ack; bus.int_done = done;
        rise = i_irq & ~m_prev;
        clr  = '0;
        if (w && a == 2'd2) clr[11:0]  = d;
        if (w && a == 2'd3) clr[23:12] = d;
        elig = m_pend & m_mask;
        if (m_phase == 0) begin
            if (elig != 0) begin
                for (int i = 23; i >= 0; i--) if (elig[i]) m_id = i;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (ack) begin
                clr[m_id] = 1'b1;
                m_phase = 2;
            end else begin
                after = (m_pend & ~clr) | rise;
                if (!(after[m_id] && m_mask[m_id])) m_phase = 0;
            end
        end else if (done) begin
            m_phase = 0;
        end
        m_pend = (m_pend & ~clr) | rise;
        if (w && a == 2'd0) m_mask[11:0]  = d;
        if (w && a == 2'd1) m_mask[23:12] = d;
        m_prev = i_irq;
        e.req = (m_phase == 1);
        e.svc = (m_phase == 2);
        e.id  = 5'(m_id);
        e.vec = 24'(int'(BASE) + 2 * m_id);
        case (a)
            2'd0:    e.rdata = m_mask[11:0];
            2'd1:    e.rdata = m_mask[23:12];
            2'd2:    e.rdata = m_pend[11:0];
            default: e.rdata = m_pend[23:12];
        endcase
        sb.push_back(e);
    endtask

    task automatic idle(input logic [1:0] a);
        step(24'd0, 1'b0, a, 12'd0, 1'b0, 1'b0);
    endtask

    // Sample just after the edge that follows the last issued step.
    task automatic settle();
        @(posedge clk); #3;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        bus.irq = '0; bus.cfg_wr = 1'b0; bus.cfg_addr = 2'd2; bus.cfg_wdata = '0;
        bus.int_ack = 1'b0; bus.int_done = 1'b0;
        #1;
        chk("rst_int_req", 24'(bus.int_req), 24'd0);
        chk("rst_in_service", 24'(bus.in_service), 24'd0);
        chk("rst_pending", 24'(bus.cfg_rdata), 24'd0);
        chk("rst_int_id", 24'(bus.int_id), 24'd0);
        chk("rst_int_vector", bus.int_vector, BASE);
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: compares every cycle for which a stimulus step was issued.
    exp_t mon_e;
    logic mon_prev_req = 1'b0;
    always begin
        @(posedge clk); #2;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("int_req", 24'(bus.int_req), 24'(mon_e.req));
            chk("in_service", 24'(bus.in_service), 24'(mon_e.svc));
            chk("int_id", 24'(bus.int_id), 24'(mon_e.id));
            chk("int_vector", bus.int_vector, mon_e.vec);
            chk("cfg_rdata", 24'(bus.cfg_rdata), 24'(mon_e.rdata));
            if (mon_e.req && !mon_prev_req)
                $display("txn: request id=%0d vector=%o", mon_e.id, mon_e.vec);
            mon_prev_req = mon_e.req;
        end
    end

    logic [23:0] r_irq;
    initial begin
        rst = 1'b1;
        bus.irq = '0; bus.cfg_wr = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = '0;
        bus.int_ack = 1'b0; bus.int_done = 1'b0;
        model_reset();
        #2;
        chk("init_int_req", 24'(bus.int_req), 24'd0);
        chk("init_in_service", 24'(bus.in_service), 24'd0);
        chk("init_int_vector", bus.int_vector, BASE);
        chk("init_mask", 24'(bus.cfg_rdata), 24'd0);
        @(negedge clk); #1 rst = 1'b0;

        // Single line, all enabled.
        step(24'd0, 1'b1, 2'd0, 12'o7777, 1'b0, 1'b0);
        step(24'd0, 1'b1, 2'd1, 12'o7777, 1'b0, 1'b0);
        step(24'd1 << 5, 1'b0, 2'd2, 12'd0, 1'b0, 1'b0);
        idle(2'd2);
        settle();
        chk("l5_req", 24'(bus.int_req), 24'd1);
        chk("l5_id", 24'(bus.int_id), 24'd5);
        chk("l5_vector", bus.int_vector, 24'o00000112);
        step(24'd0, 1'b0, 2'd0, 12'd0, 1'b1, 1'b1);
        step(24'd0, 1'b0, 2'd0, 12'd0, 1'b1, 1'b1);

        // Simultaneous lines 3 and 17.
        step((24'd1 << 3) | (24'd1 << 17), 1'b0, 2'd3, 12'd0, 1'b0, 1'b0);
        idle(2'd3);
        settle();
        chk("pri_first_id", 24'(bus.int_id), 24'd3);
        step(24'd0, 1'b0, 2'd3, 12'd0, 1'b1, 1'b0);
        step(24'd0, 1'b0, 2'd3, 12'd0, 1'b0, 1'b1);
        idle(2'd3);
        settle();
        chk("pri_second_id", 24'(bus.int_id), 24'd17);
        chk("pri_second_vector", bus.int_vector, 24'o00000142);
        step(24'd0, 1'b0, 2'd3, 12'd0, 1'b1, 1'b0);
        step(24'd0, 1'b0, 2'd3, 12'd0, 1'b0, 1'b1);

        // Masked line 9, then enabled.
        step(24'd0, 1'b1, 2'd0, 12'o6777, 1'b0, 1'b0);
        step(24'd1 << 9, 1'b0, 2'd2, 12'd0, 1'b0, 1'b0);
        idle(2'd2);
        idle(2'd2);
        settle();
        chk("masked_req", 24'(bus.int_req), 24'd0);
        chk("masked_pending", 24'(bus.cfg_rdata), 24'o1000);
        step(24'd0, 1'b1, 2'd0, 12'o7777, 1'b0, 1'b0);
        idle(2'd2);
        settle();
        chk("unmasked_req", 24'(bus.int_req), 24'd1);
        step(24'd0, 1'b0, 2'd2, 12'd0, 1'b1, 1'b0);
        step(24'd0, 1'b0, 2'd2, 12'd0, 1'b0, 1'b1);

        // Withdraw by clearing pending while in REQ.
        step(24'd1 << 4, 1'b0, 2'd2, 12'd0, 1'b0, 1'b0);
        idle(2'd2);
        step(24'd0, 1'b1, 2'd2, 12'o0020, 1'b0, 1'b0);
        settle();
        chk("withdraw_req", 24'(bus.int_req), 24'd0);
        chk("withdraw_svc", 24'(bus.in_service), 24'd0);
        idle(2'd2);

        // Clear and new edge on line 0 in the same cycle.
        step(24'd1, 1'b1, 2'd2, 12'o0001, 1'b0, 1'b0);
        settle();
        chk("set_beats_clr", 24'(bus.cfg_rdata & 12'o0001), 24'd1);
        idle(2'd2);
        idle(2'd2);
        step(24'd0, 1'b0, 2'd2, 12'd0, 1'b1, 1'b0);
        step(24'd0, 1'b0, 2'd2, 12'd0, 1'b0, 1'b1);

        // Reset during SERVICE, stray done, then a line already high at release.
        step(24'd1 << 7, 1'b0, 2'd2, 12'd0, 1'b0, 1'b0);
        idle(2'd2);
        step(24'd0, 1'b0, 2'd2, 12'd0, 1'b1, 1'b0);
        step(24'd1 << 8, 1'b0, 2'd2, 12'd0, 1'b0, 1'b0);
        do_reset();
        step(24'd0, 1'b0, 2'd2, 12'd0, 1'b0, 1'b1);
        settle();
        chk("stray_done_svc", 24'(bus.in_service), 24'd0);
        chk("stray_done_req", 24'(bus.int_req), 24'd0);
        step(24'd4, 1'b0, 2'd2, 12'd0, 1'b0, 1'b0);
        step(24'd4, 1'b0, 2'd2, 12'd0, 1'b0, 1'b0);
        idle(2'd2);

        // Randomized traffic with one reset in the middle.
        r_irq = '0;
        step(24'd0, 1'b1, 2'd0, 12'o7777, 1'b0, 1'b0);
        step(24'd0, 1'b1, 2'd1, 12'o7777, 1'b0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                do_reset();
                step(r_irq, 1'b1, 2'd0, 12'o7777, 1'b0, 1'b0);
                step(r_irq, 1'b1, 2'd1, 12'o7777, 1'b0, 1'b0);
            end
            r_irq = r_irq ^ (24'($urandom) & 24'($urandom) & 24'($urandom));
            step(r_irq, ($urandom % 10) == 0, 2'($urandom), 12'($urandom) | 12'($urandom),
                 ($urandom % 3) == 0, ($urandom % 4) == 0);
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
